// File: rtl/conv_mac_seq.sv
// Tap sequencer and result stage around an external 16-bit fixed-point MAC.
// It pairs each pixel with a weight, accumulates K taps, then rounds and saturates the window sum.
module conv_mac_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned Q = 12,
  parameter int unsigned K = 9,
  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic            clk,
  input  logic            sclr,
  input  logic            en_i,
  input  logic [N-1:0]    pix_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  input  logic            w_we_i,
  input  logic [AW-1:0]   w_addr_i,
  input  logic [N-1:0]    w_data_i,
  output logic [N-1:0]    mac_a_o,
  output logic [N-1:0]    mac_b_o,
  output logic [2*N-1:0]  mac_c_o,
  output logic            mac_ce_o,
  input  logic [2*N-1:0]  mac_r_i,
  output logic [N-1:0]    res_o,
  output logic            res_valid_o,
  input  logic            res_ready_i
);

  localparam int unsigned RW = 2 * N + 1;
  localparam logic [RW-1:0] RndHalf = RW'(1) << (Q - 1);
  localparam logic [AW-1:0] LastTap = AW'(K - 1);

  typedef enum logic [0:0] {StAcc, StDrain} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  tap_q, tap_d;
  logic [N-1:0]   res_q, res_d;
  logic           res_valid_q, res_valid_d;
  logic [N-1:0]   w_q [K];
  logic           hs;
  logic [RW-1:0]  rnd, y;
  logic [N-1:0]   sat;

  // Kernel register file; reads see the pre-write value in the write cycle.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      for (int i = 0; i < K; i++) w_q[i] <= '0;
    end else if (w_we_i && (32'(w_addr_i) < K)) begin
      w_q[w_addr_i] <= w_data_i;
    end
  end

  // Round half up in 2N+1 bits, then clamp to the N-bit range.
  always_comb begin
    rnd = {1'b0, mac_r_i} + RndHalf;
    y   = rnd >> Q;
    sat = (|y[RW-1:N]) ? '1 : y[N-1:0];
  end

  assign mac_a_o     = pix_i;
  assign mac_b_o     = w_q[tap_q];
  assign mac_c_o     = (tap_q == '0) ? '0 : mac_r_i;
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    res_d       = res_q;
    res_valid_d = res_valid_q & ~res_ready_i;
    pix_ready_o = 1'b0;
    mac_ce_o    = 1'b0;
    hs          = 1'b0;
    unique case (state_q)
      StAcc: begin
        // Gated by sclr so ready stays low for the whole reset pulse.
        pix_ready_o = en_i & ~sclr;
        hs          = pix_valid_i & pix_ready_o;
        mac_ce_o    = hs;
        if (hs) begin
          if (tap_q == LastTap) begin
            tap_d   = '0;
            state_d = StDrain;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (!res_valid_q || res_ready_i) begin
          res_d       = sat;
          res_valid_d = 1'b1;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state_q     <= StAcc;
      tap_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq with a behavioural MAC and a window-level scoreboard.
module tb_conv_mac_seq;

  localparam int unsigned N  = 16;
  localparam int unsigned Q  = 12;
  localparam int unsigned K  = 3;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          sclr;
  logic          en_i;
  logic [N-1:0]  pix_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          w_we_i;
  logic [AW-1:0] w_addr_i;
  logic [N-1:0]  w_data_i;
  logic [N-1:0]  mac_a, mac_b;
  logic [31:0]   mac_c, mac_r;
  logic          mac_ce;
  logic [N-1:0]  res_o;
  logic          res_valid_o;
  logic          res_ready_i;

  conv_mac_seq #(.N(N), .Q(Q), .K(K)) dut (
    .clk         (clk),
    .sclr        (sclr),
    .en_i        (en_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .w_we_i      (w_we_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .mac_a_o     (mac_a),
    .mac_b_o     (mac_b),
    .mac_c_o     (mac_c),
    .mac_ce_o    (mac_ce),
    .mac_r_i     (mac_r),
    .res_o       (res_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i)
  );

  always #5 clk = ~clk;

  // External MAC: r <= a*b + c when enabled, wraps mod 2^32.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) mac_r <= '0;
    else if (mac_ce) mac_r <= 32'(mac_a) * 32'(mac_b) + mac_c;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd_sat(input logic [31:0] s);
    longint unsigned y;
    y = {32'b0, s};
    y = (y + 2048) / 4096;
    if (y > 65535) return 16'hFFFF;
    return y[15:0];
  endfunction

  // Window-level reference model and result scoreboard.
  logic [15:0] w_m [K];
  logic [31:0] acc_m;
  int          tap_m;
  logic [15:0] exp_q [$];
  logic [15:0] last_res;
  int          n_res = 0;
  bit          hold;
  logic [15:0] res_prev;

  initial begin
    forever begin
      @(negedge clk);
      if (sclr) begin
        for (int i = 0; i < K; i++) w_m[i] = '0;
        acc_m = '0;
        tap_m = 0;
        exp_q.delete();
        hold = 1'b0;
      end else begin
        if (hold) chk("res_stable", {47'b0, res_valid_o, res_o}, {47'b0, 1'b1, res_prev});
        if (mac_ce) chk("ce_without_hs", 64'(pix_valid_i && pix_ready_o), 64'd1);
        if (pix_valid_i && pix_ready_o) begin
          chk("ce_on_hs", 64'(mac_ce), 64'd1);
          if (tap_m == 0) chk("mac_c_tap0", 64'(mac_c), 64'd0);
          acc_m = acc_m + 32'(pix_i) * 32'(w_m[tap_m]);
          tap_m++;
          if (tap_m == K) begin
            exp_q.push_back(rnd_sat(acc_m));
            acc_m = '0;
            tap_m = 0;
          end
        end
        if (w_we_i && w_addr_i < K) w_m[w_addr_i] = w_data_i;
        if (res_valid_o && res_ready_i) begin
          if (exp_q.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
          else chk("res_value", 64'(res_o), 64'(exp_q.pop_front()));
          last_res = res_o;
          n_res++;
        end
        hold     = res_valid_o && !res_ready_i;
        res_prev = res_o;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int addr, input logic [15:0] data);
    w_we_i   = 1'b1;
    w_addr_i = AW'(addr);
    w_data_i = data;
    step();
    w_we_i = 1'b0;
  endtask

  task automatic set_all_w(input logic [15:0] data);
    for (int i = 0; i < K; i++) wr_w(i, data);
  endtask

  task automatic send_pix(input logic [15:0] p, input bit rnd_rdy);
    int n = 0;
    pix_i       = p;
    pix_valid_i = 1'b1;
    while (!pix_ready_o && n < 200) begin
      step();
      n++;
      if (rnd_rdy && n > 3) res_ready_i = 1'b1;
    end
    if (n >= 200) chk("pix_timeout", 64'd1, 64'd0);
    step();
    pix_valid_i = 1'b0;
  endtask

  task automatic send_win(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    send_pix(a, 1'b0);
    send_pix(b, 1'b0);
    send_pix(c, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    res_ready_i = 1'b1;
    while ((exp_q.size() != 0 || res_valid_o) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n0;
    sclr = 1'b1; en_i = 1'b1; pix_i = 16'h1234; pix_valid_i = 1'b1;
    w_we_i = 1'b0; w_addr_i = '0; w_data_i = '0; res_ready_i = 1'b1;
    #3;
    chk("rst_pix_ready", 64'(pix_ready_o), 64'd0);
    chk("rst_mac_ce", 64'(mac_ce), 64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_mac_c", 64'(mac_c), 64'd0);
    step(); step();
    sclr = 1'b0; pix_valid_i = 1'b0;
    step();

    // Basic window with latency and next-window readiness.
    set_all_w(16'h1000);
    send_pix(16'h1000, 1'b0);
    send_pix(16'h2000, 1'b0);
    send_pix(16'h0800, 1'b0);
    chk("lat_not_yet", 64'(res_valid_o), 64'd0);
    chk("drain_ready_low", 64'(pix_ready_o), 64'd0);
    step();
    chk("lat_valid", 64'(res_valid_o), 64'd1);
    chk("basic_res", 64'(res_o), 64'h3800);
    chk("next_win_ready", 64'(pix_ready_o), 64'd1);
    drain();

    // Rounding at the half point and just below it.
    set_all_w(16'h0400);
    send_win(16'd1, 16'd1, 16'd0);
    drain();
    chk("round_half_up", 64'(last_res), 64'd1);
    set_all_w(16'h03FF);
    send_win(16'd1, 16'd1, 16'd0);
    drain();
    chk("round_below", 64'(last_res), 64'd0);

    // Saturation.
    set_all_w(16'h4000);
    send_win(16'hFFFF, 16'hFFFF, 16'hFFFF);
    drain();
    chk("saturate", 64'(last_res), 64'hFFFF);

    // Backpressure across two windows.
    set_all_w(16'h1000);
    n0 = n_res;
    res_ready_i = 1'b0;
    send_win(16'h1000, 16'h1000, 16'h1000);
    send_win(16'h2000, 16'h2000, 16'h2000);
    repeat (4) step();
    chk("bp_ready_low", 64'(pix_ready_o), 64'd0);
    chk("bp_valid", 64'(res_valid_o), 64'd1);
    chk("bp_first_res", 64'(res_o), 64'h3000);
    drain();
    chk("bp_count", 64'(n_res - n0), 64'd2);
    chk("bp_second_res", 64'(last_res), 64'h6000);

    // Pixel gaps and en_i low mid-window.
    for (int i = 0; i < K; i++) wr_w(i, 16'($urandom));
    send_pix(16'($urandom), 1'b0);
    en_i = 1'b0; pix_valid_i = 1'b1; pix_i = 16'($urandom);
    repeat (5) begin
      step();
      chk("en_low_ready", 64'(pix_ready_o), 64'd0);
    end
    en_i = 1'b1; pix_valid_i = 1'b0;
    repeat ($urandom_range(0, 3)) step();
    send_pix(16'($urandom), 1'b0);
    repeat ($urandom_range(1, 3)) step();
    send_pix(16'($urandom), 1'b0);
    n0 = n_res;
    drain();
    chk("gap_count", 64'(n_res - n0), 64'd1);

    // Same-cycle write to the active tap uses the old weight.
    set_all_w(16'h1000);
    send_pix(16'h1000, 1'b0);
    w_we_i = 1'b1; w_addr_i = 2'd1; w_data_i = 16'h0000;
    send_pix(16'h1000, 1'b0);
    w_we_i = 1'b0;
    send_pix(16'h1000, 1'b0);
    drain();
    chk("wr_old_weight", 64'(last_res), 64'h3000);
    send_win(16'h1000, 16'h1000, 16'h1000);
    drain();
    chk("wr_new_weight", 64'(last_res), 64'h2000);

    // Reset mid-window with a held result.
    set_all_w(16'h1000);
    res_ready_i = 1'b0;
    send_win(16'h1000, 16'h1000, 16'h1000);
    send_pix(16'h1000, 1'b0);
    pix_valid_i = 1'b1;
    sclr = 1'b1;
    #1;
    chk("mid_rst_pix_ready", 64'(pix_ready_o), 64'd0);
    chk("mid_rst_mac_ce", 64'(mac_ce), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("mid_rst_res", 64'(res_o), 64'd0);
    step();
    sclr = 1'b0; pix_valid_i = 1'b0; res_ready_i = 1'b1;
    n0 = n_res;
    send_win(16'h1000, 16'h2000, 16'h3000);
    drain();
    chk("rst_zero_weights", 64'(last_res), 64'd0);
    chk("rst_one_result", 64'(n_res - n0), 64'd1);

    // Randomized windows with random writes, gaps and sink stalls.
    repeat (25) begin
      for (int t = 0; t < K; t++) begin
        repeat ($urandom_range(0, 2)) step();
        w_we_i      = ($urandom_range(0, 3) == 0);
        w_addr_i    = AW'($urandom_range(0, 3));
        w_data_i    = 16'($urandom);
        res_ready_i = ($urandom_range(0, 3) != 0);
        send_pix(($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom), 1'b1);
        w_we_i = 1'b0;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
